ppi_sched: RTL and testbench



---
 rtl/ppi_sched_if.sv | 26 ++
 rtl/ppi_sched.sv | 101 ++++++++++
 tb/tb_ppi_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ppi_sched_if.sv
// rtl/ppi_sched_if.sv - sample-in, datapath-bank and phase-out signal bundle for ppi_sched
interface ppi_sched_if #(
    parameter int gp_idata_width          = 8,
    parameter int gp_interpolation_factor = 32,
    parameter int gp_chan_width           = 26
);
    logic                                             i_valid;
    logic [gp_idata_width-1:0]                        i_data;
    logic                                             o_ready;
    logic                                             o_filt_ena;
    logic [gp_idata_width-1:0]                        o_filt_data;
    logic [gp_chan_width*gp_interpolation_factor-1:0] i_filt_data;
    logic                                             o_valid;
    logic [gp_chan_width-1:0]                         o_data;
    logic                                             i_ready;

    modport slave (
        input  i_valid, i_data, i_filt_data, i_ready,
        output o_ready, o_filt_ena, o_filt_data, o_valid, o_data
    );

    modport master (
        output i_valid, i_data, i_filt_data, i_ready,
        input  o_ready, o_filt_ena, o_filt_data, o_valid, o_data
    );
endinterface

// File: rtl/ppi_sched.sv
// rtl/ppi_sched.sv - sequencer and phase commutator around the PPI mul_add datapath
module ppi_sched #(
    parameter int gp_idata_width          = 8,
    parameter int gp_interpolation_factor = 32,
    parameter int gp_chan_width           = 26,
    parameter bit gp_ccw                  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_an,
    input  logic        i_ena,
    ppi_sched_if.slave  bus
);
    localparam int L     = gp_interpolation_factor;
    localparam int W     = gp_chan_width;
    localparam int CNT_W = $clog2(L);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

    typedef enum logic {ST_EMPTY, ST_STREAM} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_nxt;
    logic [gp_idata_width-1:0] hold_data;
    logic                      hold_full;
    logic [L*W-1:0]            shadow;

    logic                      shadow_full;
    logic                      ready;
    logic                      accept;
    logic                      out_hs;
    logic                      last;
    logic                      cap;
    logic [CNT_W-1:0]          sel;
    logic [W-1:0]              word_mux;

    // A capture on the last handshake keeps the stream running with no bubble.
    always_comb begin
        shadow_full = (state == ST_STREAM);
        ready       = i_ena & ~hold_full;
        accept      = bus.i_valid & ready;
        out_hs      = i_ena & shadow_full & bus.i_ready;
        last        = out_hs & (cnt == CNT_LAST);
        cap         = i_ena & hold_full & (~shadow_full | last);
        state_nxt   = state;
        cnt_nxt     = cnt;
        if (cap) begin
            state_nxt = ST_STREAM;
            cnt_nxt   = '0;
        end else if (last) begin
            state_nxt = ST_EMPTY;
        end else if (out_hs) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state <= ST_EMPTY;
            cnt   <= '0;
        end else if (i_ena) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The bank is sampled while the datapath still holds pre-advance tap state.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shadow    <= '0;
        end else begin
            if (accept) begin
                hold_data <= bus.i_data;
                hold_full <= 1'b1;
            end else if (cap) begin
                hold_full <= 1'b0;
            end
            if (cap) begin
                shadow <= bus.i_filt_data;
            end
        end
    end

    always_comb begin
        sel      = gp_ccw ? (CNT_LAST - cnt) : cnt;
        word_mux = '0;
        for (int k = 0; k < L; k++) begin
            if (sel == CNT_W'(k)) begin
                word_mux = shadow[k*W +: W];
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_filt_ena  = cap;
    assign bus.o_filt_data = hold_data;
    assign bus.o_valid     = shadow_full;
    assign bus.o_data      = word_mux;
endmodule

// File: tb/tb_ppi_sched.sv
// tb/tb_ppi_sched.sv - self-checking bench for ppi_sched (L=4, W=8, both phase orders)
module tb_ppi_sched;
    localparam int L  = 4;
    localparam int W  = 8;
    localparam int DW = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic       valid = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] din   = 8'h00;
    int         mode  = 0;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] acc_q[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    bit         m_hs, m_pulse, m_acc;

    always #5 clk = ~clk;

    ppi_sched_if #(.gp_idata_width(DW), .gp_interpolation_factor(L), .gp_chan_width(W)) b0 ();
    ppi_sched_if #(.gp_idata_width(DW), .gp_interpolation_factor(L), .gp_chan_width(W)) b1 ();

    ppi_sched #(.gp_idata_width(DW), .gp_interpolation_factor(L), .gp_chan_width(W), .gp_ccw(1'b0)) u0 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .bus(b0.slave));
    ppi_sched #(.gp_idata_width(DW), .gp_interpolation_factor(L), .gp_chan_width(W), .gp_ccw(1'b1)) u1 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .bus(b1.slave));

    // Bank stub: mode 0 is the fixed {44,33,22,11} bank, mode 1 derives each phase from the sample.
    function automatic logic [7:0] word(input int md, input int k, input logic [7:0] s);
        if (md == 0) return 8'(8'h11 * (k + 1));
        return s + 8'(k * 64);
    endfunction

    always_comb begin
        b0.i_valid = valid;  b0.i_data = din;  b0.i_ready = ready;
        b1.i_valid = valid;  b1.i_data = din;  b1.i_ready = ready;
        b0.i_filt_data = '0;
        b1.i_filt_data = '0;
        for (int k = 0; k < L; k++) begin
            b0.i_filt_data[k*W +: W] = word(mode, k, b0.o_filt_data);
            b1.i_filt_data[k*W +: W] = word(mode, k, b1.o_filt_data);
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit e);
        @(posedge clk);
        #1;
        valid = v; din = d; ready = r; ena = e;
    endtask

    task automatic clr();
        acc_q.delete(); exp0.delete(); exp1.delete();
    endtask

    // Reference model: samples waiting for the datapath, and the words still owed downstream.
    always @(negedge clk) begin
        if (mon_en) begin
            m_hs    = ena && ready && (exp0.size() != 0);
            m_pulse = ena && (acc_q.size() != 0) && ((exp0.size() == 0) || (exp0.size() == 1 && m_hs));
            m_acc   = ena && valid && (acc_q.size() == 0);
            chk("o_ready", b0.o_ready, ena && (acc_q.size() == 0));
            chk("o_ready_ccw1", b1.o_ready, ena && (acc_q.size() == 0));
            chk("o_valid", b0.o_valid, exp0.size() != 0);
            chk("o_valid_ccw1", b1.o_valid, exp1.size() != 0);
            if (exp0.size() != 0) chk("o_data", b0.o_data, exp0[0]);
            if (exp1.size() != 0) chk("o_data_ccw1", b1.o_data, exp1[0]);
            chk("o_filt_ena", b0.o_filt_ena, m_pulse);
            chk("o_filt_ena_ccw1", b1.o_filt_ena, m_pulse);
            if (m_pulse) chk("o_filt_data", b0.o_filt_data, acc_q[0]);
            if (m_hs) begin
                void'(exp0.pop_front());
                if (exp1.size() != 0) void'(exp1.pop_front());
            end
            if (m_pulse) begin
                for (int k = 0; k < L; k++) begin
                    exp0.push_back(word(mode, k, acc_q[0]));
                    exp1.push_back(word(mode, L - 1 - k, acc_q[0]));
                end
                void'(acc_q.pop_front());
            end
            if (m_acc) acc_q.push_back(din);
        end
    end

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         rdy;
        bit         fe;
        logic [7:0] fd;
        bit         ov;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         cd;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] samp[3];
    int         idx, first, lastv, nv, np;
    int         pc[4];

    initial begin
        tbl[0] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 8'h11, 8'h44, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 8'h22, 8'h33, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 8'h33, 8'h22, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b1, 8'h44, 8'h11, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0};
        samp[0] = 8'h01; samp[1] = 8'h02; samp[2] = 8'h03;

        rst_n = 1'b0; ena = 1'b1;
        #12;
        chk("rst_o_valid", b0.o_valid, 0);
        chk("rst_o_data", b0.o_data, 0);
        chk("rst_o_data_ccw1", b1.o_data, 0);
        chk("rst_o_filt_data", b0.o_filt_data, 0);
        chk("rst_o_filt_ena", b0.o_filt_ena, 0);
        chk("rst_o_ready_ena1", b0.o_ready, 1);
        ena = 1'b0;
        #1;
        chk("rst_o_ready_ena0", b0.o_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        mode = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].v, tbl[i].d, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("tv%0d_o_ready", i), b0.o_ready, tbl[i].rdy);
            chk($sformatf("tv%0d_o_filt_ena", i), b0.o_filt_ena, tbl[i].fe);
            chk($sformatf("tv%0d_o_filt_data", i), b0.o_filt_data, tbl[i].fd);
            chk($sformatf("tv%0d_o_valid", i), b0.o_valid, tbl[i].ov);
            if (tbl[i].cd) begin
                chk($sformatf("tv%0d_o_data", i), b0.o_data, tbl[i].d0);
                chk($sformatf("tv%0d_o_data_ccw1", i), b1.o_data, tbl[i].d1);
            end
        end

        mode = 1; idx = 0; first = -1; lastv = -1; nv = 0; np = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(idx < 3, samp[(idx < 3) ? idx : 0], 1'b1, 1'b1);
            @(negedge clk);
            if (b0.o_filt_ena) begin
                if (np < 4) pc[np] = c;
                np++;
            end
            if (b0.o_valid) begin
                if (first < 0) first = c;
                lastv = c;
                nv++;
            end
            if (valid && b0.o_ready) idx++;
        end
        chk("burst_pulses", np, 3);
        chk("burst_gap01", pc[1] - pc[0], 4);
        chk("burst_gap12", pc[2] - pc[1], 4);
        chk("burst_words", nv, 12);
        chk("burst_span", lastv - first, 11);

        mode = 0;
        cyc(1'b1, 8'h05, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 8'h07, 1'b0, 1'b1);
            @(negedge clk);
            chk("stall_o_data", b0.o_data, 8'h22);
            chk("stall_o_data_ccw1", b1.o_data, 8'h33);
            chk("stall_o_filt_ena", b0.o_filt_ena, 0);
            if (c > 0) chk("stall_o_ready", b0.o_ready, 0);
        end
        repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("stall_drained", exp0.size(), 0);

        cyc(1'b1, 8'h05, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (5) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            chk("freeze_o_valid", b0.o_valid, 1);
            chk("freeze_o_data", b0.o_data, 8'h22);
            chk("freeze_o_filt_ena", b0.o_filt_ena, 0);
            chk("freeze_o_ready", b0.o_ready, 0);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("resume_o_data", b0.o_data, 8'h22);
        repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("resume_drained", exp0.size(), 0);

        cyc(1'b1, 8'h05, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", b0.o_valid, 0);
        chk("midrst_o_valid_ccw1", b1.o_valid, 0);
        chk("midrst_o_data", b0.o_data, 0);
        chk("midrst_o_filt_data", b0.o_filt_data, 0);
        chk("midrst_o_filt_ena", b0.o_filt_ena, 0);
        clr();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h06, 1'b1, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("postrst_phase0", b0.o_data, 8'h11);
        chk("postrst_phase0_ccw1", b1.o_data, 8'h44);
        repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("postrst_drained", exp0.size(), 0);

        mode = 1;
        for (int c = 0; c < 3000; c++) begin
            cyc(1'($urandom % 2), 8'($urandom), ($urandom % 4) != 0, ($urandom % 8) != 0);
        end
        repeat (20) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("rand_words_left", exp0.size(), 0);
        chk("rand_samples_left", acc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
